riscv_lsu_ctrl: RTL and testbench
=================================

Name: riscv_lsu_ctrl

Overview:
Load/store unit controller between the core's decode/execute stage and the data memory port. It accepts one memory request per instruction (request, write-enable, RISC-V size code, address and store data) and runs the request/acknowledge handshake with memory. It generates byte enables, aligns and sign/zero-extends load data, and stalls the core until the access completes. Misaligned accesses, illegal size codes and memory timeouts are reported as faults.

Parameters:
TIMEOUT, 255, number of BUSY cycles without mem_ack_i before the access is aborted with a timeout fault (1..255)

Ports:
clk_i  input  1  clock, rising edge
arstn_i  input  1  asynchronous active-low reset
core_req_i  input  1  memory access request from core (held until core_stall_o low)
core_we_i  input  1  1 = store, 0 = load
core_size_i  input  3  funct3 size code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
core_addr_i  input  32  byte address
core_wd_i  input  32  store data, value in low bits
core_rd_o  output  32  aligned, extended load data
core_stall_o  output  1  core must hold the current instruction
core_fault_o  output  1  access fault, valid in DONE
fault_code_o  output  2  0 none, 1 misaligned, 2 illegal size, 3 timeout
mem_req_o  output  1  memory request
mem_we_o  output  1  memory write enable
mem_be_o  output  4  byte enables
mem_addr_o  output  32  word address, bits [1:0] = 0
mem_wd_o  output  32  lane-replicated store data
mem_rd_i  input  32  memory read word
mem_ack_i  input  1  memory completion, one-cycle pulse

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: all registered outputs and core_rd_o are 0; fault_code_o is 0.
- Reset is asynchronous: asserting arstn_i mid-access drops mem_req_o immediately and discards the access.
- core_stall_o is combinational: core_req_i & (state != DONE).
- IDLE with core_req_i=1:
  - Latch we, size, addr, wd.
  - Size check: illegal when core_size_i is in {3,6,7}, and also for stores with size 4 or 5.
  - Alignment check: misaligned when a half access has addr[0]=1, or a word access has addr[1:0] != 0.
  - On either fault: go to DONE with core_fault_o=1 and fault_code_o set. No memory request is issued. Illegal size takes priority over misaligned.
  - Otherwise: go to BUSY; clear the timeout counter.
- BUSY:
  - mem_req_o=1; mem_we_o, mem_be_o, mem_addr_o ({addr[31:2],2'b00}) and mem_wd_o stay stable for the whole state.
  - mem_ack_i=1: capture mem_rd_i and go to DONE with no fault.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without an ack, go to DONE with fault_code_o=3; mem_req_o drops on that transition.
- DONE: core_stall_o=0 for exactly one cycle, then IDLE. core_fault_o and fault_code_o are valid only in DONE and are 0 elsewhere.
- mem_ack_i is ignored in IDLE and DONE.
- Latency: request seen at cycle 0 → mem_req_o high at cycle 1. An ack at cycle n (n ≥ 1) → DONE at cycle n+1. Minimum access is 3 cycles.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
  - Loads drive the same mask; mem_we_o=0.
- Store data replication:
  - byte: {4{wd[7:0]}}
  - half: {2{wd[15:0]}}
  - word: wd
- Load extraction:
  - Select the lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- core_rd_o is registered. It is updated only on a successful load completion and holds its value otherwise, including across stores and faults.
- core_req_i sampled in DONE is ignored. A back-to-back request is accepted in the following IDLE cycle.

Test Plan:
- LW addr 0x100, ack after 2 BUSY cycles, mem_rd_i 0xDEADBEEF → mem_addr_o 0x100, be 1111, stall high for 3 cycles, core_rd_o 0xDEADBEEF, fault 0.
- LB addr 0x103, mem_rd_i 0x80FF0000 → be 1000, core_rd_o 0xFFFFFF80. Repeat as LBU → core_rd_o 0x00000080.
- SH addr 0x202, wd 0x1234ABCD → mem_we_o 1, be 1100, mem_wd_o 0xABCDABCD, mem_addr_o 0x200, core_rd_o unchanged.
- LW addr 0x101 → no mem_req_o, DONE one cycle after the request, fault_code_o 1. Store with size 4 → fault_code_o 2.
- TIMEOUT=4, no ack → mem_req_o high exactly 4 cycles, then DONE with fault_code_o 3 and stall released.
- arstn_i low during BUSY → mem_req_o falls without a clock edge. After release, state is IDLE and a new LW completes normally.

Source files
------------

// File: rtl/riscv_lsu_ctrl.sv
// riscv_lsu_ctrl: load/store unit controller between execute and the data port.
// Runs the mem req/ack handshake, builds byte lanes, extends loads, flags faults.
module riscv_lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_fault_o,
    output logic [1:0]  fault_code_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        size_ill;
    logic        misal;
    logic [3:0]  be_d;
    logic [31:0] wd_d;
    logic [31:0] lane;
    logic [31:0] rd_d;

    assign core_stall_o = core_req_i & (state_q != DONE);

    // Decode the incoming request: access width, faults, lanes, store data
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        unique case (core_size_i)
            3'd0, 3'd4: is_byte = 1'b1;
            3'd1, 3'd5: is_half = 1'b1;
            3'd2:       is_word = 1'b1;
            default:    ;
        endcase
        size_ill = ~(is_byte | is_half | is_word)
                 | (core_we_i & core_size_i[2]);
        misal = (is_half & core_addr_i[0])
              | (is_word & (|core_addr_i[1:0]));
        be_d = 4'b1111;
        wd_d = core_wd_i;
        if (is_byte) begin
            be_d = 4'b0001 << core_addr_i[1:0];
            wd_d = {4{core_wd_i[7:0]}};
        end else if (is_half) begin
            be_d = 4'b0011 << core_addr_i[1:0];
            wd_d = {2{core_wd_i[15:0]}};
        end
    end

    // Pick the addressed lane out of the read word and extend it
    always_comb begin
        lane = mem_rd_i >> {off_q, 3'b000};
        unique case (size_q)
            3'd0:    rd_d = {{24{lane[7]}}, lane[7:0]};
            3'd1:    rd_d = {{16{lane[15]}}, lane[15:0]};
            3'd4:    rd_d = {24'd0, lane[7:0]};
            3'd5:    rd_d = {16'd0, lane[15:0]};
            default: rd_d = mem_rd_i;
        endcase
    end

    // Access FSM with registered memory, fault and load-data outputs
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            size_q       <= 3'd0;
            off_q        <= 2'd0;
            core_rd_o    <= 32'd0;
            core_fault_o <= 1'b0;
            fault_code_o <= 2'd0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_be_o     <= 4'd0;
            mem_addr_o   <= 32'd0;
            mem_wd_o     <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (core_req_i) begin
                        size_q <= core_size_i;
                        off_q  <= core_addr_i[1:0];
                        if (size_ill) begin
                            state_q      <= DONE;
                            core_fault_o <= 1'b1;
                            fault_code_o <= 2'd2;
                        end else if (misal) begin
                            state_q      <= DONE;
                            core_fault_o <= 1'b1;
                            fault_code_o <= 2'd1;
                        end else begin
                            state_q    <= BUSY;
                            cnt_q      <= 8'd0;
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= core_we_i;
                            mem_be_o   <= be_d;
                            mem_addr_o <= {core_addr_i[31:2], 2'b00};
                            mem_wd_o   <= wd_d;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack_i || cnt_q == CNT_LAST) begin
                        state_q    <= DONE;
                        mem_req_o  <= 1'b0;
                        mem_we_o   <= 1'b0;
                        mem_be_o   <= 4'd0;
                        mem_addr_o <= 32'd0;
                        mem_wd_o   <= 32'd0;
                        if (mem_ack_i) begin
                            if (!mem_we_o) begin
                                core_rd_o <= rd_d;
                            end
                        end else begin
                            core_fault_o <= 1'b1;
                            fault_code_o <= 2'd3;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    core_fault_o <= 1'b0;
                    fault_code_o <= 2'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// tb_riscv_lsu_ctrl: directed and randomized checks of riscv_lsu_ctrl
// against a behavioural model of the load/store rules.
module tb_riscv_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        arstn_i;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'd0;
    logic [31:0] core_addr_i = 32'd0;
    logic [31:0] core_wd_i = 32'd0;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_fault_o;
    logic [1:0]  fault_code_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i = 32'd0;
    logic        mem_ack_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    int          obs_stall;
    int          obs_req;
    logic        obs_we;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr;
    logic [31:0] obs_wd;
    logic        obs_fault;
    logic [1:0]  obs_code;
    logic [31:0] obs_rd;
    bit          obs_unstable;
    bit          obs_leak;
    bit          obs_to;

    logic [31:0] exp_rd = 32'd0;

    riscv_lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .arstn_i      (arstn_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .core_fault_o (core_fault_o),
        .fault_code_o (fault_code_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk = ~clk;

    function automatic int exp_code(input logic we, input int sz, input logic [31:0] a);
        bit legal;
        int w;
        legal = we ? (sz <= 2) : (sz != 3 && sz <= 5);
        if (!legal) return 2;
        w = 1 << (sz % 4);
        if (int'(a[1:0]) % w != 0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] exp_load(input int sz, input logic [31:0] a, input logic [31:0] d);
        longint v;
        longint u;
        int sh;
        sh = 8 * int'(a[1:0]);
        u = longint'(d);
        case (sz)
            0: begin v = (u >> sh) % 256; if (v >= 128) v = v - 256; end
            1: begin v = (u >> sh) % 65536; if (v >= 32768) v = v - 65536; end
            4: v = (u >> sh) % 256;
            5: v = (u >> sh) % 65536;
            default: v = u;
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_be(input int sz, input logic [31:0] a);
        int w;
        w = 1 << (sz % 4);
        return 4'(((1 << w) - 1) << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] exp_wd(input int sz, input logic [31:0] wd);
        case (sz)
            0: return 32'(longint'(wd % 256) * 32'h01010101);
            1: return 32'(longint'(wd % 65536) * 32'h00010001);
            default: return wd;
        endcase
    endfunction

    // Drives one access and acts as memory; records what the DUT showed.
    task automatic run_access(input logic we, input logic [2:0] sz,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ack_at, input logic [31:0] rdata,
                              input bit hold);
        int busy;
        int cyc;
        bit seen;
        bit fin;
        obs_stall = 0; obs_unstable = 0; obs_leak = 0; obs_to = 0;
        obs_fault = 0; obs_code = 0; obs_we = 0; obs_be = 0;
        obs_addr = 0; obs_wd = 0;
        core_req_i = 1'b1; core_we_i = we; core_size_i = sz;
        core_addr_i = a; core_wd_i = wd; mem_rd_i = rdata;
        busy = 0; cyc = 0; seen = 0; fin = 0;
        while (!fin) begin
            #1;
            if (core_stall_o) begin
                seen = 1;
                obs_stall++;
                if (core_fault_o || fault_code_o != 2'd0) obs_leak = 1;
            end else if (seen) begin
                fin = 1;
                obs_fault = core_fault_o;
                obs_code = fault_code_o;
                obs_rd = core_rd_o;
            end
            if (mem_req_o) begin
                if (busy == 0) begin
                    obs_we = mem_we_o; obs_be = mem_be_o;
                    obs_addr = mem_addr_o; obs_wd = mem_wd_o;
                end else if (obs_we !== mem_we_o || obs_be !== mem_be_o ||
                             obs_addr !== mem_addr_o || obs_wd !== mem_wd_o) begin
                    obs_unstable = 1;
                end
                busy++;
                mem_ack_i = (busy == ack_at);
            end else begin
                mem_ack_i = 1'b0;
            end
            if (fin) begin
                if (!hold) core_req_i = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
                if (cyc > 300) begin
                    obs_to = 1; fin = 1; core_req_i = 1'b0; mem_ack_i = 1'b0;
                end
            end
        end
        obs_req = busy;
    endtask

    task automatic test_reset();
        arstn_i = 1'b0;
        #2;
        n_cmp++;
        if ({core_rd_o, core_fault_o, fault_code_o} !== 35'd0) begin
            n_bad++; $display("FAIL reset_core: got %h want 0", {core_rd_o, core_fault_o, fault_code_o});
        end
        n_cmp++;
        if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o} !== 70'd0) begin
            n_bad++; $display("FAIL reset_mem: got %h want 0", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o});
        end
        n_cmp++;
        if (core_stall_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_stall: got %b want 0", core_stall_o);
        end
        @(negedge clk);
        arstn_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw();
        run_access(1'b0, 3'd2, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0);
        exp_rd = 32'hDEADBEEF;
        n_cmp++;
        if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_we !== 1'b0) begin
            n_bad++; $display("FAIL lw_mem: got addr %h be %b we %b want 100 1111 0", obs_addr, obs_be, obs_we);
        end
        n_cmp++;
        if (obs_stall != 3) begin
            n_bad++; $display("FAIL lw_stall: got %0d want 3", obs_stall);
        end
        n_cmp++;
        if (obs_rd !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL lw_rd: got %h want deadbeef", obs_rd);
        end
        n_cmp++;
        if (obs_fault !== 1'b0 || obs_code !== 2'd0) begin
            n_bad++; $display("FAIL lw_fault: got %b/%0d want 0/0", obs_fault, obs_code);
        end
        @(negedge clk);
    endtask

    task automatic test_lb();
        run_access(1'b0, 3'd0, 32'h103, 32'h0, 1, 32'h80FF0000, 1'b0);
        n_cmp++;
        if (obs_be !== 4'b1000 || obs_rd !== 32'hFFFFFF80) begin
            n_bad++; $display("FAIL lb: got be %b rd %h want 1000 ffffff80", obs_be, obs_rd);
        end
        @(negedge clk);
        run_access(1'b0, 3'd4, 32'h103, 32'h0, 1, 32'h80FF0000, 1'b0);
        exp_rd = 32'h00000080;
        n_cmp++;
        if (obs_be !== 4'b1000 || obs_rd !== 32'h00000080) begin
            n_bad++; $display("FAIL lbu: got be %b rd %h want 1000 00000080", obs_be, obs_rd);
        end
        @(negedge clk);
    endtask

    task automatic test_sh();
        run_access(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 3, 32'h55555555, 1'b0);
        n_cmp++;
        if (obs_we !== 1'b1 || obs_be !== 4'b1100 || obs_wd !== 32'hABCDABCD || obs_addr !== 32'h200) begin
            n_bad++; $display("FAIL sh_mem: got we %b be %b wd %h addr %h want 1 1100 abcdabcd 200",
                              obs_we, obs_be, obs_wd, obs_addr);
        end
        n_cmp++;
        if (obs_rd !== exp_rd || obs_unstable) begin
            n_bad++; $display("FAIL sh_rd: got %h unstable %b want %h 0", obs_rd, obs_unstable, exp_rd);
        end
        @(negedge clk);
    endtask

    task automatic test_faults();
        run_access(1'b0, 3'd2, 32'h101, 32'h0, 1, 32'h12345678, 1'b0);
        n_cmp++;
        if (obs_req != 0 || obs_stall != 1 || obs_fault !== 1'b1 || obs_code !== 2'd1) begin
            n_bad++; $display("FAIL misalign: got req %0d stall %0d fault %b code %0d want 0 1 1 1",
                              obs_req, obs_stall, obs_fault, obs_code);
        end
        @(negedge clk);
        run_access(1'b1, 3'd4, 32'h300, 32'h0, 1, 32'h0, 1'b0);
        n_cmp++;
        if (obs_req != 0 || obs_fault !== 1'b1 || obs_code !== 2'd2) begin
            n_bad++; $display("FAIL st_size4: got req %0d fault %b code %0d want 0 1 2", obs_req, obs_fault, obs_code);
        end
        @(negedge clk);
        run_access(1'b0, 3'd7, 32'h303, 32'h0, 1, 32'h0, 1'b0);
        n_cmp++;
        if (obs_code !== 2'd2 || obs_rd !== exp_rd) begin
            n_bad++; $display("FAIL ill_prio: got code %0d rd %h want 2 %h", obs_code, obs_rd, exp_rd);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        run_access(1'b0, 3'd2, 32'h400, 32'h0, 0, 32'hCAFEF00D, 1'b0);
        n_cmp++;
        if (obs_req != TO || obs_stall != TO + 1) begin
            n_bad++; $display("FAIL timeout_len: got req %0d stall %0d want %0d %0d", obs_req, obs_stall, TO, TO + 1);
        end
        n_cmp++;
        if (obs_fault !== 1'b1 || obs_code !== 2'd3 || obs_rd !== exp_rd || obs_leak) begin
            n_bad++; $display("FAIL timeout_fault: got %b/%0d rd %h leak %b want 1/3 %h 0",
                              obs_fault, obs_code, obs_rd, obs_leak, exp_rd);
        end
        @(negedge clk);
        run_access(1'b0, 3'd5, 32'h402, 32'h0, TO, 32'h8001FFFF, 1'b0);
        exp_rd = 32'h00008001;
        n_cmp++;
        if (obs_code !== 2'd0 || obs_rd !== exp_rd || obs_req != TO) begin
            n_bad++; $display("FAIL late_ack: got code %0d rd %h req %0d want 0 %h %0d", obs_code, obs_rd, obs_req, exp_rd, TO);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 3'd1, 32'h500, 32'h0, 1, 32'h0000F00F, 1'b1);
        n_cmp++;
        if (obs_rd !== 32'hFFFFF00F) begin
            n_bad++; $display("FAIL b2b_first: got %h want fffff00f", obs_rd);
        end
        run_access(1'b0, 3'd2, 32'h504, 32'h0, 2, 32'h0BADCAFE, 1'b0);
        exp_rd = 32'h0BADCAFE;
        n_cmp++;
        if (obs_stall != 3 || obs_rd !== exp_rd || obs_addr !== 32'h504) begin
            n_bad++; $display("FAIL b2b_second: got stall %0d rd %h addr %h want 3 %h 504",
                              obs_stall, obs_rd, obs_addr, exp_rd);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int cyc;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = 32'h40; mem_ack_i = 1'b0;
        cyc = 0;
        while (!mem_req_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (mem_req_o !== 1'b1) begin
            n_bad++; $display("FAIL arst_busy: got req %b want 1", mem_req_o);
        end
        #2;
        arstn_i = 1'b0;
        #1;
        n_cmp++;
        if (mem_req_o !== 1'b0 || core_rd_o !== 32'd0 || core_fault_o !== 1'b0) begin
            n_bad++; $display("FAIL arst_drop: got req %b rd %h fault %b want 0 0 0", mem_req_o, core_rd_o, core_fault_o);
        end
        exp_rd = 32'd0;
        core_req_i = 1'b0;
        @(negedge clk);
        arstn_i = 1'b1;
        @(negedge clk);
        run_access(1'b0, 3'd2, 32'h44, 32'h0, 1, 32'h11223344, 1'b0);
        exp_rd = 32'h11223344;
        n_cmp++;
        if (obs_stall != 2 || obs_rd !== exp_rd || obs_code !== 2'd0) begin
            n_bad++; $display("FAIL arst_after: got stall %0d rd %h code %0d want 2 %h 0", obs_stall, obs_rd, obs_code, exp_rd);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic        we;
            int          sz;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] rdata;
            int          ack_at;
            int          code;
            int          e_req;
            we = 1'($urandom_range(0, 1));
            sz = int'($urandom_range(0, 7));
            a = $urandom;
            wd = $urandom;
            rdata = $urandom;
            ack_at = int'($urandom_range(0, TO));
            run_access(we, 3'(sz), a, wd, ack_at, rdata, 1'($urandom_range(0, 1)));
            code = exp_code(we, sz, a);
            e_req = 0;
            if (code == 0) begin
                e_req = (ack_at == 0) ? TO : ack_at;
                if (ack_at == 0) code = 3;
                else if (!we) exp_rd = exp_load(sz, a, rdata);
            end
            n_cmp++;
            if (obs_req != e_req || obs_stall != e_req + 1 || obs_to) begin
                n_bad++; $display("FAIL rnd%0d_len: got req %0d stall %0d want %0d %0d", i, obs_req, obs_stall, e_req, e_req + 1);
            end
            n_cmp++;
            if (obs_code !== 2'(code) || obs_fault !== (code != 0) || obs_leak) begin
                n_bad++; $display("FAIL rnd%0d_fault: got %b/%0d leak %b want %0d", i, obs_fault, obs_code, obs_leak, code);
            end
            n_cmp++;
            if (obs_rd !== exp_rd) begin
                n_bad++; $display("FAIL rnd%0d_rd: got %h want %h", i, obs_rd, exp_rd);
            end
            if (e_req > 0) begin
                n_cmp++;
                if (obs_we !== we || obs_be !== exp_be(sz, a) || obs_addr !== (a & 32'hFFFFFFFC) ||
                    (we && obs_wd !== exp_wd(sz, wd)) || obs_unstable) begin
                    n_bad++; $display("FAIL rnd%0d_mem: got we %b be %b addr %h wd %h unstable %b want %b %b %h %h",
                                      i, obs_we, obs_be, obs_addr, obs_wd, obs_unstable,
                                      we, exp_be(sz, a), a & 32'hFFFFFFFC, exp_wd(sz, wd));
                end
            end
            if (core_req_i == 1'b0 || $urandom_range(0, 1) == 0) begin
                core_req_i = 1'b0;
                @(negedge clk);
            end
        end
        core_req_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_faults();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
